// File: rtl/sram_ctrl_multibeat.sv
// rtl/sram_ctrl_multibeat.sv - multi-beat, wait-stated asynchronous SRAM controller
module sram_ctrl_multibeat #(
  parameter int WORD_W   = 32,
  parameter int SRAM_DW  = 16,
  parameter int SRAM_AW  = 18,
  parameter int WAIT_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [WORD_W-1:0]   write_data,
  input  logic [WORD_W/8-1:0] byte_en,
  output logic [WORD_W-1:0]   read_data,
  output logic                ready,
  output logic                busy,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  localparam int BEATS    = WORD_W / SRAM_DW;
  localparam int BYTES    = WORD_W / 8;
  localparam int BPB      = SRAM_DW / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [31:0]         word_idx_q, word_idx_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]    ben_q, ben_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WORD_W-1:0]   read_data_q, read_data_d;

  logic [SRAM_DW-1:0]  beat_wdata;
  logic [BPB-1:0]      beat_ben;
  logic                last_cyc;
  logic                dq_oe;

  // Select the captured write slice and byte enables belonging to the current beat
  always_comb begin
    beat_wdata = '0;
    beat_ben   = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        beat_wdata = wdata_q[k*SRAM_DW +: SRAM_DW];
        beat_ben   = ben_q[k*BPB +: BPB];
      end
    end
  end

  // Next-state logic: accept a request, step through beats and wait cycles, then pulse done
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    wdata_d     = wdata_q;
    ben_d       = ben_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    read_data_d = read_data_q;
    last_cyc    = (wait_q == LAST_WAIT);
    case (state_q)
      S_IDLE: begin
        if (wr_en || rd_en) begin
          // write has priority when both enables are seen together
          state_d    = wr_en ? S_WRITE : S_READ;
          word_idx_d = address >> OFF_BITS;
          wdata_d    = write_data;
          ben_d      = byte_en;
          beat_d     = '0;
          wait_d     = '0;
        end
      end
      S_WRITE, S_READ: begin
        if ((state_q == S_READ) && last_cyc) begin
          // data is sampled only on the final wait cycle of each beat
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
              read_data_d[k*SRAM_DW +: SRAM_DW] = SRAM_DQ;
            end
          end
        end
        if (last_cyc) begin
          wait_d = '0;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM strobes and address decoded from registered state and counters only
  always_comb begin
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_CE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    case (state_q)
      S_WRITE: begin
        SRAM_CE_N = 1'b0;
        // a beat with no enabled bytes still burns its cycles but never strobes WE
        SRAM_WE_N = ~(|beat_ben);
        SRAM_UB_N = ~beat_ben[1];
        SRAM_LB_N = ~beat_ben[0];
        SRAM_ADDR = SRAM_AW'(word_idx_q * 32'(BEATS) + 32'(beat_q));
        dq_oe     = 1'b1;
      end
      S_READ: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_ADDR = SRAM_AW'(word_idx_q * 32'(BEATS) + 32'(beat_q));
      end
      default: begin
        dq_oe = 1'b0;
      end
    endcase
  end

  assign SRAM_DQ   = dq_oe ? beat_wdata : {SRAM_DW{1'bz}};
  assign read_data = read_data_q;
  assign ready     = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  // State and capture registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      wdata_q     <= '0;
      ben_q       <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      wdata_q     <= wdata_d;
      ben_q       <= ben_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      read_data_q <= read_data_d;
    end
  end

endmodule
